// File: rtl/ins_queue_reg.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO of {pc, ins} pairs.
// Decouples instruction fetch from decode; ir_write pops the oldest entry into the IR.
module ins_queue_reg #(
  parameter int unsigned      WIDTH = 32,
  parameter int unsigned      DEPTH = 4,
  parameter logic [WIDTH-1:0] NOP   = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_ins,
  input  logic [WIDTH-1:0]           in_pc,
  input  logic                       ir_write,
  output logic [WIDTH-1:0]           ins_out,
  output logic [WIDTH-1:0]           pc_out,
  output logic                       ir_valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] ins_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem  [DEPTH];

  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] ins_q, ins_d, pc_q, pc_d;
  logic             valid_q, valid_d;

  logic push, load, not_empty;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != CW'(DEPTH));
  // Flush discards anything that would have happened in the same cycle.
  assign push      = in_valid && in_ready && !flush;
  assign load      = ir_write && not_empty && !flush;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ins_d   = ins_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      ins_d   = NOP;
      pc_d    = '0;
      valid_d = 1'b0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (ir_write) begin
        if (not_empty) begin
          ins_d   = ins_mem[rp_q];
          pc_d    = pc_mem[rp_q];
          rp_d    = rp_q + AW'(1);
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      count_d = count_q + CW'(push) - CW'(load);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ins_q   <= NOP;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ins_q   <= ins_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ins_mem[wp_q] <= in_ins;
      pc_mem[wp_q]  <= in_pc;
    end
  end

  assign ins_out  = ins_q;
  assign pc_out   = pc_q;
  assign ir_valid = valid_q;
  assign count    = count_q;

endmodule

// File: doc/ins_queue_reg.md
# ins_queue_reg

Parametrised instruction register with a built-in prefetch queue for the multi-cycle CPU datapath. Fetched instruction words and their PCs are buffered in a DEPTH-entry FIFO. A handshaked `ir_write` moves the oldest entry into the architectural instruction register, which holds its value between loads. Sits between instruction memory and the decode/control stage, and replaces the single-word IR with a fetch/decode decoupling point.

## Interface
Parameters:
- `WIDTH`, 32, instruction word and PC width in bits
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2
- `NOP`, 32'h0000_0000, value loaded into `ins_out` on reset and flush

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge
- `rst`  input  1  asynchronous, active-low reset (0 = reset)
- `flush`  input  1  synchronous queue/IR clear (branch/jump redirect)
- `in_valid`  input  1  fetch side presents a word
- `in_ready`  output  1  queue can accept; equals (count != DEPTH)
- `in_ins`  input  WIDTH  fetched instruction
- `in_pc`  input  WIDTH  PC of fetched instruction
- `ir_write`  input  1  control unit requests the next instruction into the IR
- `ins_out`  output  WIDTH  instruction register contents (registered)
- `pc_out`  output  WIDTH  PC of `ins_out` (registered)
- `ir_valid`  output  1  `ins_out` holds a real instruction loaded by the last `ir_write`
- `count`  output  $clog2(DEPTH)+1  number of queued entries

## Operation
- Storage: DEPTH×(2·WIDTH) array, write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits and wrapping modulo DEPTH. `count` is a separate register, 0..DEPTH.
- Push: when `in_valid && in_ready`, write {`in_pc`,`in_ins`} at `wp`, then `wp++`.
- Load: when `ir_write && count != 0`:
  - `ins_out` ← entry[rp].ins
  - `pc_out` ← entry[rp].pc
  - `rp++`
  - `ir_valid` ← 1
- Stall bubble: when `ir_write && count == 0`, `ins_out` and `pc_out` hold and `ir_valid` ← 0.
- Hold: when `ir_write == 0`, `ins_out`, `pc_out` and `ir_valid` all hold, unconditionally.
- Count update: `count` += push − load. A simultaneous push and load leaves `count` unchanged.
- Full: `in_ready` = 0, so no push can occur. A load in the same cycle does not raise `in_ready` until the next cycle (no combinational ready path).
- Empty: there is no bypass. A push and `ir_write` in the same cycle stores the word, produces a bubble (`ir_valid` ← 0), and the word loads on the next `ir_write`.
- Flush has the highest priority and is synchronous. It forces `wp` = `rp` = 0, `count` = 0, `ins_out` = NOP, `pc_out` = 0 and `ir_valid` = 0. Any push or load in the same cycle is discarded.
- Reset (`rst` = 0, asynchronous) forces the same state as flush. Reset mid-operation discards all queued entries.
- `in_ready` is derived from `count` only, so it is glitch-free relative to the inputs.

## Timing
- Reset values:
  - `ins_out` = NOP
  - `pc_out` = 0
  - `ir_valid` = 0
  - `count` = 0
  - `in_ready` = 1
- Push-to-IR latency is 1 cycle minimum: push at edge N, `ir_write` asserted in cycle N+1, `ins_out` valid after edge N+1.
- Sustained throughput is 1 push + 1 load per cycle when 0 < count < DEPTH.
- Outputs change only on a rising `clk` edge, or asynchronously when `rst` falls.
- Array contents are not reset; only the pointers and `count` are.

## Test plan
- Reset then idle: hold `rst` = 0 for 2 cycles, release -> `ins_out` = 0, `ir_valid` = 0, `count` = 0, `in_ready` = 1; all hold with no stimulus.
- Fill and drain (DEPTH = 4): push 0x20080001..0x20080004 with PCs 0x0, 0x4, 0x8, 0xC -> `count` = 4, `in_ready` = 0. A fifth push is ignored. Four `ir_write` pulses -> `ins_out` shows the words in order with matching `pc_out`, and `count` returns to 0.
- Hold semantics: load 0x8C020000, then keep `ir_write` = 0 for 5 cycles while pushing 2 words -> `ins_out` stays 0x8C020000, `ir_valid` stays 1, `count` = 2.
- Empty bubble: `count` = 0, assert `ir_write` together with a push of 0x00221820 -> `ins_out` unchanged, `ir_valid` = 0, `count` = 1. Next `ir_write` -> `ins_out` = 0x00221820, `ir_valid` = 1.
- Simultaneous push/load with wrap: run 10 cycles of push + `ir_write` at `count` = 2 -> `count` stays 2, pointers wrap past 3→0, and the output order matches the push order exactly.
- Flush and reset mid-stream: with `count` = 3 and `ir_valid` = 1, assert `flush` together with a push -> next cycle `count` = 0, `ins_out` = 0, `ir_valid` = 0, and the pushed word is lost. Repeat with an asynchronous `rst` pulse between edges -> outputs clear immediately.
